// File: rtl/fir_frame_arbiter.sv
// Round-robin, frame-granular arbiter sharing one FIR datapath among NUM_REQ sources,
// zero-flushing the delay line between frames. Optional macro FIR_ARB_TAIL_EN tags the flush tail.
module fir_frame_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 64,
    parameter int TAPS      = 16,
    parameter int LATENCY   = 1
) (
    input  logic                         system1000,
    input  logic                         system1000_rst,
    input  logic [16*NUM_REQ-1:0]        in_data,
    input  logic [NUM_REQ-1:0]           in_valid,
    output logic [NUM_REQ-1:0]           in_ready,
    output logic signed [15:0]           fir_in,
    input  logic signed [15:0]           fir_out,
    output logic signed [15:0]           out_data,
    output logic                         out_valid,
    output logic [$clog2(NUM_REQ)-1:0]   out_id,
    output logic                         out_last,
    output logic                         underrun,
    output logic [1:0]                   state_dbg
);
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int CNT_W      = $clog2(FRAME_LEN + 1);
    localparam int FCNT_W     = $clog2(TAPS + 1);
    localparam int FLUSH_LAST = (TAPS >= 2) ? TAPS - 2 : 0;
    localparam bit HAS_TAIL   = (TAPS > 1);

    // Encoding is visible on state_dbg: FLUSH=0, IDLE=1, FEED=2.
    typedef enum logic [1:0] {FLUSH = 2'd0, IDLE = 2'd1, FEED = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic                tail_q, tail_d;

    logic                tag_v_d, tag_l_d;
    logic [ID_W-1:0]     tag_id_d;
    logic                tag_v_q  [LATENCY];
    logic                tag_l_q  [LATENCY];
    logic [ID_W-1:0]     tag_id_q [LATENCY];

    logic                found;
    logic [ID_W-1:0]     pick;
    logic                accept;
    logic                flush_done;
    logic                frame_end;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && in_valid[(int'(last_grant_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        sample_cnt_d = sample_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        tail_d       = tail_q;
        in_ready     = '0;
        fir_in       = '0;
        underrun     = 1'b0;
        accept       = 1'b0;
        tag_v_d      = 1'b0;
        tag_l_d      = 1'b0;
        tag_id_d     = '0;
        flush_done   = (flush_cnt_q >= FCNT_W'(FLUSH_LAST));
        frame_end    = (sample_cnt_q == CNT_W'(FRAME_LEN - 1));
        case (state_q)
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
`ifdef FIR_ARB_TAIL_EN
                // Flush zeros after a frame finish its convolution tail.
                tag_v_d  = tail_q && HAS_TAIL;
                tag_id_d = grant_q;
                tag_l_d  = tail_q && HAS_TAIL && flush_done;
`endif
                if (flush_done) begin
                    state_d = IDLE;
                    tail_d  = 1'b0;
                end
            end
            IDLE: begin
                if (found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    sample_cnt_d = '0;
                    state_d      = FEED;
                end
            end
            FEED: begin
                in_ready[grant_q] = 1'b1;
                accept   = in_valid[grant_q];
                tag_id_d = grant_q;
                tag_v_d  = accept;
                if (accept) begin
                    fir_in       = in_data[int'(grant_q)*16 +: 16];
                    sample_cnt_d = sample_cnt_q + 1'b1;
`ifdef FIR_ARB_TAIL_EN
                    tag_l_d = frame_end && !HAS_TAIL;
`else
                    tag_l_d = frame_end;
`endif
                    if (frame_end) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                        tail_d      = 1'b1;
                    end
                end else begin
                    underrun = 1'b1;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            sample_cnt_q <= '0;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            tail_q       <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_v_q[i]  <= 1'b0;
                tag_l_q[i]  <= 1'b0;
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            tail_q       <= tail_d;
            tag_v_q[0]   <= tag_v_d;
            tag_l_q[0]   <= tag_l_d;
            tag_id_q[0]  <= tag_id_d;
            for (int i = 1; i < LATENCY; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_l_q[i]  <= tag_l_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    assign out_data  = fir_out;
    assign out_valid = tag_v_q[LATENCY-1];
    assign out_id    = tag_id_q[LATENCY-1];
    assign out_last  = tag_l_q[LATENCY-1];
    assign state_dbg = state_q;
endmodule

// File: tb/tb_fir_frame_arbiter.sv
// Directed bench for fir_frame_arbiter with a 3-tap [1,1,1] FIR behavioural model.
module tb_fir_frame_arbiter;
  localparam int NR = 4;
  localparam int FL = 4;
  localparam int TP = 3;
  localparam int LT = 1;
  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
`ifdef FIR_ARB_TAIL_EN
  localparam logic TAIL = 1'b1;
`else
  localparam logic TAIL = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  logic [16*NR-1:0]  in_data = '0;
  logic [NR-1:0]     in_valid = '0;
  logic [NR-1:0]     in_ready;
  logic signed [15:0] fir_in;
  logic signed [15:0] fir_out = '0;
  logic signed [15:0] out_data;
  logic              out_valid;
  logic [1:0]        out_id;
  logic              out_last;
  logic              underrun;
  logic [1:0]        state_dbg;

  fir_frame_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .TAPS(TP), .LATENCY(LT)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fir_in         (fir_in),
    .fir_out        (fir_out),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_id         (out_id),
    .out_last       (out_last),
    .underrun       (underrun),
    .state_dbg      (state_dbg)
  );

  // FIR model: y[t+1] = x[t] + x[t-1] + x[t-2]
  logic signed [15:0] h1 = '0;
  logic signed [15:0] h2 = '0;
  always @(posedge clk) begin
    fir_out <= fir_in + h1 + h2;
    h1 <= fir_in;
    h2 <= h1;
  end

  // event monitors sampled on the falling edge
  int und_cnt = 0;
  int vld_cnt = 0;
  int lst_cnt = 0;
  always @(negedge clk) begin
    if (underrun === 1'b1) und_cnt++;
    if (out_valid === 1'b1) vld_cnt++;
    if (out_last === 1'b1) lst_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input logic [15:0] v);
    in_data[r*16 +: 16] = v;
  endtask

  logic [15:0] rr_val [NR];

  initial begin
    rr_val[0] = 16'd100; rr_val[1] = 16'd200; rr_val[2] = 16'd300; rr_val[3] = 16'd400;

    // reset check
    rst = 1'b1;
    tick(); tick();
    chk("rst_state", state_dbg, S_FLUSH);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fir_in", fir_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_in_ready", in_ready, 0);
    tick();
    chk("flush1_state", state_dbg, S_FLUSH);
    chk("flush1_in_ready", in_ready, 0);
    chk("flush1_fir_in", fir_in, 0);
    tick();
    chk("flush_to_idle", state_dbg, S_IDLE);
    chk("idle_out_valid", out_valid, 0);

    // single frame from requester 1
    in_valid = 4'b0010;
    set_data(1, 16'd1);
    tick();
    chk("sf_state_feed", state_dbg, S_FEED);
    chk("sf_in_ready", in_ready, 4'b0010);
    chk("sf_fir_in", fir_in, 1);
    tick();
    chk("sf_o1_valid", out_valid, 1);
    chk("sf_o1_id", out_id, 1);
    chk("sf_o1_data", out_data, 1);
    chk("sf_o1_last", out_last, 0);
    set_data(1, 16'd2);
    tick();
    chk("sf_o2_data", out_data, 3);
    set_data(1, 16'd3);
    tick();
    chk("sf_o3_data", out_data, 6);
    set_data(1, 16'd4);
    tick();
    chk("sf_o4_data", out_data, 9);
    chk("sf_o4_valid", out_valid, 1);
    chk("sf_o4_last", out_last, !TAIL);
    chk("sf_end_state", state_dbg, S_FLUSH);
    in_valid = 4'b0000;
    #1;
    chk("sf_flush_in_ready", in_ready, 0);
    chk("sf_flush_fir_in", fir_in, 0);
    tick();
    chk("sf_t1_data", out_data, 7);
    chk("sf_t1_valid", out_valid, TAIL);
    chk("sf_t1_last", out_last, 0);
    if (TAIL) chk("sf_t1_id", out_id, 1);
    tick();
    chk("sf_t2_data", out_data, 4);
    chk("sf_t2_valid", out_valid, TAIL);
    chk("sf_t2_last", out_last, TAIL);
    chk("sf_idle", state_dbg, S_IDLE);

    // round-robin with all requesters valid, starting from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("rr_idle0", state_dbg, S_IDLE);
    for (int r = 0; r < NR; r++) set_data(r, rr_val[r]);
    in_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      tick();
      chk($sformatf("rr%0d_in_ready", f), in_ready, 32'(1) << (f % NR));
      chk($sformatf("rr%0d_fir_in", f), fir_in, rr_val[f % NR]);
      tick();
      chk($sformatf("rr%0d_first_valid", f), out_valid, 1);
      chk($sformatf("rr%0d_first_id", f), out_id, f % NR);
      chk($sformatf("rr%0d_first_data", f), out_data, rr_val[f % NR]);
      tick(); tick(); tick();
      chk($sformatf("rr%0d_last_data", f), out_data, 3 * rr_val[f % NR]);
      chk($sformatf("rr%0d_last_flag", f), out_last, !TAIL);
      tick(); tick();
      chk($sformatf("rr%0d_idle", f), state_dbg, S_IDLE);
    end

    // underrun on requester 2 after its second sample
    in_valid = 4'b0100;
    set_data(2, 16'd5);
    und_cnt = 0;
    vld_cnt = 0;
    tick();
    chk("ur_in_ready", in_ready, 4'b0100);
    tick();
    chk("ur_o1_data", out_data, 5);
    chk("ur_o1_id", out_id, 2);
    set_data(2, 16'd6);
    tick();
    chk("ur_o2_data", out_data, 11);
    in_valid = 4'b0000;
    #1;
    chk("ur_pulse", underrun, 1);
    chk("ur_fir_in_zero", fir_in, 0);
    chk("ur_ready_held", in_ready, 4'b0100);
    tick();
    chk("ur_gap_untagged", out_valid, 0);
    in_valid = 4'b0100;
    set_data(2, 16'd7);
    #1;
    chk("ur_pulse_gone", underrun, 0);
    tick();
    chk("ur_o3_valid", out_valid, 1);
    chk("ur_o3_data", out_data, 13);
    set_data(2, 16'd8);
    tick();
    chk("ur_o4_data", out_data, 15);
    chk("ur_o4_last", out_last, !TAIL);
    chk("ur_flush", state_dbg, S_FLUSH);
    in_valid = 4'b0000;
    tick();
    chk("ur_pulse_count", und_cnt, 1);
    chk("ur_valid_count", vld_cnt, 4);
    tick();
    chk("ur_idle", state_dbg, S_IDLE);

    // reset in the middle of a frame owned by requester 3
    in_valid = 4'b1000;
    set_data(3, 16'd50);
    tick();
    chk("rm_grant3", in_ready, 4'b1000);
    lst_cnt = 0;
    tick();
    chk("rm_o1_id", out_id, 3);
    tick();
    chk("rm_o2_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 4'b1111;
    tick();
    rst = 1'b0;
    chk("rm_ready_drop", in_ready, 0);
    chk("rm_tags_dropped", out_valid, 0);
    chk("rm_state_flush", state_dbg, S_FLUSH);
    tick();
    chk("rm_flush2", state_dbg, S_FLUSH);
    chk("rm_flush_untagged", out_valid, 0);
    tick();
    chk("rm_idle", state_dbg, S_IDLE);
    chk("rm_idle_untagged", out_valid, 0);
    tick();
    chk("rm_regrant_state", state_dbg, S_FEED);
    chk("rm_regrant0", in_ready, 4'b0001);
    chk("rm_regrant_fir_in", fir_in, rr_val[0]);
    chk("rm_no_last", lst_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
